// File: rtl/register_file.sv
// register_file: Depth x DataWidth register file with one load/inc/dec/clear port and two registered read ports.
// Define REGFILE_BYPASS_EN to forward a same-cycle modify result to the read ports; default returns the old value.
module register_file #(
    parameter int DataWidth = 8,
    parameter int Depth = 8,
    localparam int AddrWidth = $clog2(Depth)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 LD,
    input  logic [1:0]           Op,
    input  logic [AddrWidth-1:0] WAddr,
    input  logic [DataWidth-1:0] DIn,
    input  logic [AddrWidth-1:0] RAddrA,
    input  logic [AddrWidth-1:0] RAddrB,
    output logic [DataWidth-1:0] DOutA,
    output logic [DataWidth-1:0] DOutB,
    output logic                 Wrap,
    output logic                 Zero
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    localparam logic [DataWidth-1:0] ONE = DataWidth'(1);

    logic [DataWidth-1:0] entries [Depth];
    logic [DataWidth-1:0] cur_val;
    logic [DataWidth-1:0] new_val;
    logic                 wrap_next;
    logic [DataWidth-1:0] val_a;
    logic [DataWidth-1:0] val_b;

    always_comb begin
        cur_val   = entries[WAddr];
        new_val   = cur_val;
        wrap_next = 1'b0;
        case (op_t'(Op))
            OP_LOAD: new_val = DIn;
            OP_INC: begin
                new_val   = cur_val + ONE;
                wrap_next = &cur_val;
            end
            OP_DEC: begin
                new_val   = cur_val - ONE;
                wrap_next = ~|cur_val;
            end
            OP_CLR:  new_val = '0;
            default: new_val = cur_val;
        endcase
    end

`ifdef REGFILE_BYPASS_EN
    // A read that collides with this cycle's modify sees the value being written.
    assign val_a = (!LD && (WAddr == RAddrA)) ? new_val : entries[RAddrA];
    assign val_b = (!LD && (WAddr == RAddrB)) ? new_val : entries[RAddrB];
`else
    assign val_a = entries[RAddrA];
    assign val_b = entries[RAddrB];
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < Depth; i++) begin
                entries[i] <= '0;
            end
            DOutA <= '0;
            DOutB <= '0;
            Wrap  <= 1'b0;
            Zero  <= 1'b0;
        end else begin
            DOutA <= val_a;
            DOutB <= val_b;
            if (!LD) begin
                entries[WAddr] <= new_val;
                Wrap           <= wrap_next;
                Zero           <= ~|new_val;
            end else begin
                Wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file: an 8x8 instance and a 16-bit x 4 instance sharing one clock.
module tb_register_file;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    int          n_tests = 0;
    int          n_fail = 0;

    // 8-bit, 8-entry instance
    logic        ld = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [2:0]  waddr = '0;
    logic [7:0]  din = '0;
    logic [2:0]  raddr_a = '0;
    logic [2:0]  raddr_b = '0;
    logic [7:0]  dout_a;
    logic [7:0]  dout_b;
    logic        wrap;
    logic        zero;

    // 16-bit, 4-entry instance
    logic        b_ld = 1'b1;
    logic [1:0]  b_op = 2'b00;
    logic [1:0]  b_waddr = '0;
    logic [15:0] b_din = '0;
    logic [1:0]  b_raddr_a = '0;
    logic [1:0]  b_raddr_b = '0;
    logic [15:0] b_dout_a;
    logic [15:0] b_dout_b;
    logic        b_wrap;
    logic        b_zero;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    register_file #(.DataWidth(8), .Depth(8)) dut (
        .Clk(Clk), .Reset(Reset), .LD(ld), .Op(op), .WAddr(waddr), .DIn(din),
        .RAddrA(raddr_a), .RAddrB(raddr_b), .DOutA(dout_a), .DOutB(dout_b),
        .Wrap(wrap), .Zero(zero)
    );

    register_file #(.DataWidth(16), .Depth(4)) dut_w (
        .Clk(Clk), .Reset(Reset), .LD(b_ld), .Op(b_op), .WAddr(b_waddr), .DIn(b_din),
        .RAddrA(b_raddr_a), .RAddrB(b_raddr_b), .DOutA(b_dout_a), .DOutB(b_dout_b),
        .Wrap(b_wrap), .Zero(b_zero)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modify(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d);
        ld = 1'b0; op = o; waddr = a; din = d;
        tick();
        ld = 1'b1;
    endtask

    task automatic b_modify(input logic [1:0] o, input logic [1:0] a, input logic [15:0] d);
        b_ld = 1'b0; b_op = o; b_waddr = a; b_din = d;
        tick();
        b_ld = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        check("reset_douta", 16'(dout_a), 16'h0);
        check("reset_doutb", 16'(dout_b), 16'h0);
        check("reset_wrap", 16'(wrap), 16'h0);
        check("reset_zero", 16'(zero), 16'h0);
        #2 Reset = 1'b0;
        tick();

        // Build up non-zero state, then reset between edges
        modify(OP_LOAD, 3'd3, 8'h5A);
        modify(OP_LOAD, 3'd2, 8'hFF);
        raddr_a = 3'd3; raddr_b = 3'd3;
        modify(OP_INC, 3'd2, 8'h00);
        check("pre_reset_douta", 16'(dout_a), 16'h5A);
        check("pre_reset_doutb", 16'(dout_b), 16'h5A);
        check("pre_reset_wrap", 16'(wrap), 16'h1);
        check("pre_reset_zero", 16'(zero), 16'h1);
        #2 Reset = 1'b1;
        #1;
        check("async_douta", 16'(dout_a), 16'h0);
        check("async_doutb", 16'(dout_b), 16'h0);
        check("async_wrap", 16'(wrap), 16'h0);
        check("async_zero", 16'(zero), 16'h0);
        #2 Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            tick();
            check("post_reset_entry_a", 16'(dout_a), 16'h0);
            check("post_reset_entry_b", 16'(dout_b), 16'h0);
        end

        // Load/read
        for (int i = 0; i < 8; i++) begin
            modify(OP_LOAD, 3'(i), 8'(8'h10 + i));
        end
        raddr_a = 3'd2; raddr_b = 3'd7;
        tick();
        check("read_a2", 16'(dout_a), 16'h12);
        check("read_b7", 16'(dout_b), 16'h17);
        raddr_a = 3'd5; raddr_b = 3'd5;
        tick();
        check("read_same_a5", 16'(dout_a), 16'h15);
        check("read_same_b5", 16'(dout_b), 16'h15);

        // Increment wrap on entry 1
        modify(OP_LOAD, 3'd1, 8'hFE);
        modify(OP_INC, 3'd1, 8'h00);
        check("inc1_wrap", 16'(wrap), 16'h0);
        check("inc1_zero", 16'(zero), 16'h0);
        raddr_a = 3'd1;
        modify(OP_INC, 3'd1, 8'h00);
        check("inc2_wrap", 16'(wrap), 16'h1);
        check("inc2_zero", 16'(zero), 16'h1);
        tick();
        check("idle_wrap", 16'(wrap), 16'h0);
        check("idle_zero_hold", 16'(zero), 16'h1);
        check("inc_entry1", 16'(dout_a), 16'h00);

        // Decrement wrap on entry 4
        modify(OP_CLR, 3'd4, 8'h77);
        check("clr_zero", 16'(zero), 16'h1);
        check("clr_wrap", 16'(wrap), 16'h0);
        modify(OP_DEC, 3'd4, 8'h00);
        check("dec_wrap", 16'(wrap), 16'h1);
        check("dec_zero", 16'(zero), 16'h0);
        raddr_a = 3'd4;
        tick();
        check("dec_entry4", 16'(dout_a), 16'hFF);

        // Plain decrement, no wrap
        modify(OP_DEC, 3'd5, 8'h00);
        check("dec5_wrap", 16'(wrap), 16'h0);
        raddr_b = 3'd5;
        tick();
        check("dec_entry5", 16'(dout_b), 16'h14);

        // Same-cycle read/modify on entry 6
        modify(OP_LOAD, 3'd6, 8'h20);
        raddr_a = 3'd6;
        modify(OP_INC, 3'd6, 8'h00);
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_read", 16'(dout_a), 16'h21);
`else
        check("same_cycle_read", 16'(dout_a), 16'h20);
`endif
        tick();
        check("next_cycle_read", 16'(dout_a), 16'h21);

        // Back-to-back increments on entry 7
        modify(OP_INC, 3'd7, 8'h00);
        modify(OP_INC, 3'd7, 8'h00);
        modify(OP_INC, 3'd7, 8'h00);
        raddr_b = 3'd7;
        tick();
        check("b2b_inc_entry7", 16'(dout_b), 16'h1A);

        // Modify pending while reset deasserts is applied on the first edge
        #1 Reset = 1'b1;
        ld = 1'b0; op = OP_LOAD; waddr = 3'd2; din = 8'h33;
        #3 Reset = 1'b0;
        tick();
        ld = 1'b1;
        check("pending_zero", 16'(zero), 16'h0);
        check("pending_wrap", 16'(wrap), 16'h0);
        raddr_a = 3'd2; raddr_b = 3'd7;
        tick();
        check("pending_entry2", 16'(dout_a), 16'h33);
        check("pending_entry7_cleared", 16'(dout_b), 16'h0);

        // 16-bit, 4-entry instance
        b_modify(OP_LOAD, 2'd0, 16'h1234);
        b_modify(OP_LOAD, 2'd1, 16'hABCD);
        b_modify(OP_LOAD, 2'd3, 16'hFFFF);
        check("w_load_zero", 16'(b_zero), 16'h0);
        b_modify(OP_INC, 2'd3, 16'h0000);
        check("w_inc_wrap", 16'(b_wrap), 16'h1);
        check("w_inc_zero", 16'(b_zero), 16'h1);
        b_raddr_a = 2'd3; b_raddr_b = 2'd0;
        tick();
        check("w_entry3", b_dout_a, 16'h0000);
        check("w_entry0", b_dout_b, 16'h1234);
        check("w_idle_wrap", 16'(b_wrap), 16'h0);
        b_raddr_a = 2'd1; b_raddr_b = 2'd2;
        tick();
        check("w_entry1", b_dout_a, 16'hABCD);
        check("w_entry2", b_dout_b, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-entry register file that generalises the single load/reset register into Depth entries. It has one write/modify port with four operations and two registered read ports. It sits in the datapath between the ALU result bus and the operand buses, and holds general registers and pointer registers. Pointers use the built-in increment/decrement operation, so they need no ALU pass.

## Interface
Parameters:
- DataWidth, 8, bits per entry
- Depth, 8, number of entries; must be a power of two and ≥2
- AddrWidth, $clog2(Depth), address width; derived, not overridden

Ports:
- Clk  input  1  clock; all state updates on posedge
- Reset  input  1  asynchronous, active-high reset
- LD  input  1  modify strobe, active low; when low, Op is applied to entry WAddr
- Op  input  2  00 load DIn, 01 increment, 10 decrement, 11 clear
- WAddr  input  AddrWidth  target entry of the modify port
- DIn  input  DataWidth  load data; used only when Op=00
- RAddrA  input  AddrWidth  read port A address
- RAddrB  input  AddrWidth  read port B address
- DOutA  output  DataWidth  registered read data, port A
- DOutB  output  DataWidth  registered read data, port B
- Wrap  output  1  registered; 1 for one cycle after an inc/dec that wrapped
- Zero  output  1  registered; 1 when the entry value written by the last modify is all zeros

## Operation
- Reset asserted, asynchronous: all entries 0; DOutA=DOutB=0; Wrap=0; Zero=0.
- Modify path, on the posedge where LD=0:
  - Op=00: entry[WAddr] <= DIn.
  - Op=01: entry[WAddr] <= entry[WAddr]+1, modulo 2^DataWidth.
  - Op=10: entry[WAddr] <= entry[WAddr]-1, modulo 2^DataWidth.
  - Op=11: entry[WAddr] <= 0.
- Modify path, on the posedge where LD=1: no entry changes; Wrap <= 0; Zero holds its previous value.
- Wrap: set to 1 on the modify edge only for increment from all-ones to 0, or decrement from 0 to all-ones. Otherwise 0.
- Zero: on a modify edge, set to (new entry value == 0).
- Read path, every posedge: DOutA <= value(RAddrA); DOutB <= value(RAddrB). Reads never affect entries.
- value(x) is defined by the Configuration section. Both ports may address the same entry, and both then return identical data.
- Out-of-range addresses cannot occur because Depth is a power of two.

## Timing
- Modify latency: 1 cycle. The entry is updated on the same edge LD is sampled low.
- Read latency: 1 cycle. The address is presented in cycle N and data appears after the edge closing cycle N.
- Wrap and Zero are valid in the cycle after the modify edge, aligned with DOut of a same-address read issued with the modify.
- Back-to-back modifies to the same entry: each edge uses the result of the previous edge. Three consecutive increments add 3.
- Reset asserted mid-operation: state clears immediately, independent of Clk. The first edge after deassertion operates normally. A modify pending at deassertion is applied on that edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - value(x) = post-modify value of entry[x] if LD=0 and WAddr==x in the same cycle; otherwise entry[x].
  - A read issued together with a modify to the same address returns the new value.
- REGFILE_BYPASS_EN undefined:
  - value(x) = entry[x] before the edge, i.e. the old value.
  - The new value is visible to a read issued in the following cycle.
- Modify semantics, Wrap, Zero and reset are identical in both builds.

## Test plan
- Reset mid-stream: load entry 3 = 0x5A, then assert Reset between edges. DOutA, DOutB, Wrap, Zero and all entries must read 0 immediately.
- Load/read: load entries 0..7 with 0x10..0x17. Read A=2, B=7 → DOutA=0x12, DOutB=0x17 one cycle later. A=B=5 → both 0x15.
- Increment wrap: load entry 1 = 0xFE; increment, increment. Entry values 0xFF then 0x00. Wrap=0 then 1; Zero=0 then 1. An idle cycle (LD=1) → Wrap=0.
- Decrement wrap: clear entry 4 (Zero=1), then decrement → entry 4 = 0xFF, Wrap=1, Zero=0.
- Same-cycle read/modify: entry 6 = 0x20; increment 6 while RAddrA=6. Bypass build → DOutA=0x21. Non-bypass build → DOutA=0x20, and 0x21 on the next read.
- Width parameter: DataWidth=16, Depth=4. Load 0xFFFF into entry 3, increment → 0x0000 with Wrap=1. Other entries stay unchanged.
